// File: rtl/scaler_h_linear.sv
// Horizontal 2-tap linear resampler: a per-line position accumulator walks a
// two-pixel input window and feeds a 2-stage multiply / round pipeline.
module scaler_h_linear #(
  parameter int LINE_STEP   = 128,
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_SIZE_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LINE_SIZE_W-1:0] line_in_size,
  input  logic [15:0]            scale_step,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   err_o,
  output logic [1:0]             state_o
);
  localparam int K     = $clog2(LINE_STEP);
  localparam int PW    = PIXEL_WIDTH;
  localparam int NW    = LINE_SIZE_W + 1;  // n counts up to line_in_size+1
  localparam int POS_W = NW + K;           // headroom for pos past the last output
  localparam int MW    = PW + K + 1;
  localparam logic [K:0]    COEF_ONE = (K+1)'(LINE_STEP);
  localparam logic [MW-1:0] ROUND    = MW'(LINE_STEP / 2);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [NW-1:0]          n_q, n_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [PW-1:0]          p0_q, p0_d, p1_q, p1_d;
  logic [LINE_SIZE_W-1:0] size_q, size_d;
  logic [15:0]            step_q, step_d;
  logic                   err_q, err_d, hs_pend_q, hs_pend_d, vs_pend_q, vs_pend_d;
  logic                   v1_q, v1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [MW-1:0]          m0_q, m0_d, m1_q, m1_d;
  logic [PW-1:0]          do_q, do_d;
  logic                   de_q, de_d, hso_q, hso_d, vso_q, vso_d;

  logic [NW-1:0]          idx, idx_after, size_x;
  logic [K-1:0]           frac;
  logic [POS_W-1:0]       limit, pos_issue;
  logic                   win_ready, issue, accept, overrun, rep;
  logic [PW-1:0]          a_op;
  logic [K:0]             coef0, coef1;

  assign idx    = pos_q[POS_W-1:K];
  assign frac   = pos_q[K-1:0];
  assign size_x = {1'b0, size_q};
  assign limit  = {size_x, {K{1'b0}}};

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    size_d    = size_q;
    step_d    = step_q;
    err_d     = err_q & ~vs_i;
    hs_pend_d = hs_pend_q;
    vs_pend_d = vs_pend_q | vs_i;
    issue     = 1'b0;
    rep       = 1'b0;
    win_ready = (n_q == idx + NW'(2));

    case (state_q)
      RUN: begin
        issue = win_ready;
        if (n_q == size_x + NW'(1)) state_d = FLUSH;
      end
      FLUSH: begin
        // Past the last input pixel the right tap replicates the edge pixel.
        rep   = !win_ready;
        issue = (win_ready || idx == size_x) && (pos_q <= limit);
        if (pos_q > limit) state_d = IDLE;
      end
      default: ;
    endcase

    pos_issue = pos_q;
    if (issue) begin
      pos_issue = pos_q + POS_W'(step_q);
      hs_pend_d = 1'b0;
      vs_pend_d = vs_i;
    end
    idx_after = pos_issue[POS_W-1:K];

    // A new pixel while the current window still owes an output is an overrun:
    // drop the rest of that window and jump pos onto the new window.
    accept  = (state_q == RUN) && de_i && (n_q <= size_x);
    overrun = accept && (n_q == idx_after + NW'(2));
    pos_d   = pos_issue;
    if (accept) begin
      n_d  = n_q + NW'(1);
      p0_d = p1_q;
      p1_d = di_i;
    end
    if (overrun) begin
      err_d = 1'b1;
      pos_d = {n_q - NW'(1), {K{1'b0}}};
    end

    a_op  = rep ? p1_q : p0_q;
    coef1 = {1'b0, frac};
    coef0 = COEF_ONE - coef1;
    m0_d  = MW'(a_op) * MW'(coef0);
    m1_d  = MW'(p1_q) * MW'(coef1);
    v1_d  = issue;
    hs1_d = issue & hs_pend_q;
    vs1_d = issue & vs_pend_q;
    de_d  = v1_q;
    hso_d = hs1_q;
    vso_d = vs1_q;
    do_d  = v1_q ? PW'((m0_q + m1_q + ROUND) >> K) : do_q;

    if (hs_i) begin
      state_d   = (scale_step == 16'd0) ? IDLE : RUN;
      n_d       = '0;
      pos_d     = '0;
      size_d    = line_in_size;
      step_d    = scale_step;
      hs_pend_d = 1'b1;
      vs_pend_d = vs_pend_q | vs_i;
      err_d     = (err_q & ~vs_i) | (scale_step == 16'd0);
      v1_d      = 1'b0;
      hs1_d     = 1'b0;
      vs1_d     = 1'b0;
      de_d      = 1'b0;
      hso_d     = 1'b0;
      vso_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      pos_q     <= '0;
      p0_q      <= '0;
      p1_q      <= '0;
      size_q    <= '0;
      step_q    <= '0;
      err_q     <= 1'b0;
      hs_pend_q <= 1'b0;
      vs_pend_q <= 1'b0;
      v1_q      <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      m0_q      <= '0;
      m1_q      <= '0;
      do_q      <= '0;
      de_q      <= 1'b0;
      hso_q     <= 1'b0;
      vso_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      pos_q     <= pos_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      size_q    <= size_d;
      step_q    <= step_d;
      err_q     <= err_d;
      hs_pend_q <= hs_pend_d;
      vs_pend_q <= vs_pend_d;
      v1_q      <= v1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      m0_q      <= m0_d;
      m1_q      <= m1_d;
      do_q      <= do_d;
      de_q      <= de_d;
      hso_q     <= hso_d;
      vso_q     <= vso_d;
    end
  end

  assign do_o    = do_q;
  assign de_o    = de_q;
  assign hs_o    = hso_q;
  assign vs_o    = vso_q;
  assign err_o   = err_q;
  assign state_o = state_q;
endmodule
